pso_scheduler: RTL and testbench

PSO_SCHEDULER -- requirements
Module: pso_scheduler

---
 rtl/pso_pkg.sv | 38 +++
 rtl/pso_scheduler_if.sv | 27 ++
 rtl/pso_particle_regs.sv | 64 ++++++
 rtl/pso_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pso_scheduler.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pso_pkg.sv
// Shared types, constants and helpers for the particle-swarm duty-cycle scheduler.
// Positions are duty-cycle codes; powers are unsigned converter power readings.
package pso_pkg;

    localparam int DW = 16;
    typedef logic [DW-1:0] word_t;

    localparam word_t XSTEP = 16'd4096;
    localparam word_t XMIN  = 16'd256;
    localparam word_t XMAX  = 16'd61440;

    typedef enum logic [2:0] {
        IDLE,
        MEAS_REQ,
        MEAS_WAIT,
        EVAL,
        UPD_RUN,
        UPD_CAP,
        NEXT,
        DONE
    } state_t;

    // Initial spread: particles start evenly spaced XSTEP apart.
    function automatic word_t xseed(input int i);
        return word_t'((i + 1) * int'(XSTEP));
    endfunction

    function automatic word_t sat16(input logic [31:0] v);
        return (v[31:16] != '0) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic word_t clamp_x(input word_t v);
        if (v < XMIN) return XMIN;
        if (v > XMAX) return XMAX;
        return v;
    endfunction

endpackage

// File: rtl/pso_scheduler_if.sv
// Measurement handshake and update-datapath bus between the scheduler and its environment.
interface pso_scheduler_if;
    import pso_pkg::*;

    word_t       duty_out;
    logic        meas_req;
    logic        meas_ack;
    word_t       meas_pwr;
    logic        upd_ena;
    word_t       upd_vin;
    word_t       upd_p;
    word_t       upd_g;
    word_t       upd_x;
    logic [31:0] upd_vout;
    logic [31:0] upd_xout;

    modport master (
        output duty_out, meas_req, upd_ena, upd_vin, upd_p, upd_g, upd_x,
        input  meas_ack, meas_pwr, upd_vout, upd_xout
    );

    modport slave (
        input  duty_out, meas_req, upd_ena, upd_vin, upd_p, upd_g, upd_x,
        output meas_ack, meas_pwr, upd_vout, upd_xout
    );

endinterface

// File: rtl/pso_particle_regs.sv
// Per-particle state: position X, velocity V, personal-best position Pbx and power Pbp.
// One shared index serves reads and writes; init seeds the whole swarm in one cycle.
module pso_particle_regs
    import pso_pkg::*;
#(
    parameter int NPART = 4,
    localparam int IW = $clog2(NPART)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic [IW-1:0] idx,
    output word_t         x_rd,
    output word_t         v_rd,
    output word_t         pbx_rd,
    output word_t         pbp_rd,
    input  logic          pb_we,
    input  word_t         pbx_wr,
    input  word_t         pbp_wr,
    input  logic          xv_we,
    input  word_t         x_wr,
    input  word_t         v_wr
);

    word_t x_q   [NPART];
    word_t v_q   [NPART];
    word_t pbx_q [NPART];
    word_t pbp_q [NPART];

    // NOTE: this array is small flop storage, not RAM, so it is reset like any
    // other register; a reset RAM macro would not map and would need a clear FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPART; i++) begin
                x_q[i]   <= '0;
                v_q[i]   <= '0;
                pbx_q[i] <= '0;
                pbp_q[i] <= '0;
            end
        end else if (init) begin
            for (int i = 0; i < NPART; i++) begin
                x_q[i]   <= xseed(i);
                v_q[i]   <= '0;
                pbx_q[i] <= xseed(i);
                pbp_q[i] <= '0;
            end
        end else begin
            if (pb_we) begin
                pbx_q[idx] <= pbx_wr;
                pbp_q[idx] <= pbp_wr;
            end
            if (xv_we) begin
                x_q[idx] <= x_wr;
                v_q[idx] <= v_wr;
            end
        end
    end

    assign x_rd   = x_q[idx];
    assign v_rd   = v_q[idx];
    assign pbx_rd = pbx_q[idx];
    assign pbp_rd = pbp_q[idx];

endmodule

// File: rtl/pso_scheduler.sv
// Particle-swarm MPPT scheduler: measures each particle's duty cycle, tracks personal and
// global bests, and sequences an external velocity/position update datapath per particle.
module pso_scheduler
    import pso_pkg::*;
#(
    parameter int NPART    = 4,
    parameter int MAX_ITER = 60,
    parameter int UPD_LAT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    pso_scheduler_if.master bus,
    output logic            busy,
    output logic            done,
    output logic [5:0]      iter,
    output word_t           gbest_x,
    output word_t           gbest_pwr
);

    localparam int IW = $clog2(NPART);
    localparam int CW = $clog2(UPD_LAT + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NPART - 1);
    localparam logic [5:0]    LAST_ITER = 6'(MAX_ITER - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(UPD_LAT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] upd_cnt;
    word_t         meas_cap;
    word_t         duty_q;

    logic  init;
    logic  pb_we;
    logic  xv_we;
    word_t x_rd;
    word_t v_rd;
    word_t pbx_rd;
    word_t pbp_rd;
    word_t x_wr;
    word_t v_wr;

    pso_particle_regs #(.NPART(NPART)) u_regs (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (init),
        .idx    (idx),
        .x_rd   (x_rd),
        .v_rd   (v_rd),
        .pbx_rd (pbx_rd),
        .pbp_rd (pbp_rd),
        .pb_we  (pb_we),
        .pbx_wr (x_rd),
        .pbp_wr (meas_cap),
        .xv_we  (xv_we),
        .x_wr   (x_wr),
        .v_wr   (v_wr)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE) && (state != DONE);
        done         = (state == DONE);
        init         = 1'b0;
        pb_we        = 1'b0;
        xv_we        = 1'b0;
        x_wr         = clamp_x(sat16(bus.upd_xout));
        v_wr         = sat16(bus.upd_vout);
        bus.duty_out = duty_q;
        bus.meas_req = 1'b0;
        bus.upd_ena  = 1'b0;
        bus.upd_vin  = '0;
        bus.upd_p    = '0;
        bus.upd_g    = '0;
        bus.upd_x    = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    init      = 1'b1;
                    state_nxt = MEAS_REQ;
                end
            end
            MEAS_REQ: begin
                bus.meas_req = 1'b1;
                bus.duty_out = x_rd;
                state_nxt    = MEAS_WAIT;
            end
            MEAS_WAIT: begin
                bus.meas_req = 1'b1;
                if (bus.meas_ack) state_nxt = EVAL;
            end
            EVAL: begin
                pb_we     = (meas_cap > pbp_rd);
                state_nxt = (idx == LAST_IDX) ? UPD_RUN : MEAS_REQ;
            end
            UPD_RUN: begin
                bus.upd_ena = 1'b1;
                bus.upd_vin = v_rd;
                bus.upd_p   = pbx_rd;
                bus.upd_g   = gbest_x;
                bus.upd_x   = x_rd;
                if (upd_cnt == LAST_CNT) state_nxt = UPD_CAP;
            end
            UPD_CAP: begin
                xv_we     = 1'b1;
                state_nxt = (idx == LAST_IDX) ? NEXT : UPD_RUN;
            end
            NEXT: begin
                state_nxt = (iter == LAST_ITER) ? DONE : MEAS_REQ;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            upd_cnt   <= '0;
            iter      <= '0;
            gbest_x   <= '0;
            gbest_pwr <= '0;
            meas_cap  <= '0;
            duty_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        iter      <= '0;
                        gbest_x   <= xseed(0);
                        gbest_pwr <= '0;
                    end
                end
                MEAS_REQ: duty_q <= x_rd;
                MEAS_WAIT: begin
                    if (bus.meas_ack) meas_cap <= bus.meas_pwr;
                end
                EVAL: begin
                    // Strict compare: on a tie the earlier particle keeps the global best.
                    if (meas_cap > gbest_pwr) begin
                        gbest_pwr <= meas_cap;
                        gbest_x   <= x_rd;
                    end
                    idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    upd_cnt <= '0;
                end
                UPD_RUN: upd_cnt <= upd_cnt + 1'b1;
                UPD_CAP: begin
                    upd_cnt <= '0;
                    idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                NEXT: begin
                    iter <= iter + 1'b1;
                    idx  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pso_scheduler.sv
// Directed bench: two schedulers (MAX_ITER=1 and MAX_ITER=60) with a delayed-ack power source
// and a constant-output update stub; monitors log duty values and update bursts.
module tb_pso_scheduler;

    localparam logic [15:0] SEED0 = 16'h1000;
    localparam logic [15:0] SEED1 = 16'h2000;
    localparam logic [15:0] X_MIN = 16'h0100;
    localparam logic [15:0] X_MAX = 16'hF000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [2];
    logic        stray_ack [2];
    logic        mon_clr;
    int          ack_delay;
    logic [15:0] pwr_seq [4];
    logic [31:0] stub_v;
    logic [31:0] stub_x;

    wire         busy_w [2];
    wire         done_w [2];
    wire [5:0]   iter_w [2];
    wire [15:0]  gbx_w [2];
    wire [15:0]  gbp_w [2];
    wire [15:0]  duty_w [2];
    wire         mreq_w [2];
    wire         uena_w [2];
    wire [31:0]  meas_cnt_w [2];
    wire [31:0]  ms_cnt_w [2];
    wire [31:0]  bursts_w [2];
    wire [31:0]  bad_w [2];
    wire [31:0]  unstable_w [2];
    wire [31:0]  idle_nz_w [2];
    wire [127:0] duty_log_w [2];
    wire [511:0] burst_log_w [2];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pso_scheduler_if ifc ();

        pso_scheduler #(.NPART(4), .MAX_ITER(g == 0 ? 1 : 60), .UPD_LAT(4)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .bus       (ifc.master),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .iter      (iter_w[g]),
            .gbest_x   (gbx_w[g]),
            .gbest_pwr (gbp_w[g])
        );

        logic         ack_r;
        logic [15:0]  pwr_r;
        logic         mreq_d;
        logic [63:0]  held;
        logic [127:0] duty_log;
        logic [511:0] burst_log;
        int wait_cnt, meas_cnt, ms_cnt, ena_run, bursts, bad, unstable, idle_nz;
        wire [63:0] upd_bus = {ifc.upd_vin, ifc.upd_p, ifc.upd_g, ifc.upd_x};

        assign ifc.meas_ack = ack_r | stray_ack[g];
        assign ifc.meas_pwr = stray_ack[g] ? 16'hFFFF : pwr_r;
        assign ifc.upd_vout = stub_v;
        assign ifc.upd_xout = stub_x;

        assign duty_w[g]      = ifc.duty_out;
        assign mreq_w[g]      = ifc.meas_req;
        assign uena_w[g]      = ifc.upd_ena;
        assign meas_cnt_w[g]  = meas_cnt;
        assign ms_cnt_w[g]    = ms_cnt;
        assign bursts_w[g]    = bursts;
        assign bad_w[g]       = bad;
        assign unstable_w[g]  = unstable;
        assign idle_nz_w[g]   = idle_nz;
        assign duty_log_w[g]  = duty_log;
        assign burst_log_w[g] = burst_log;

        always @(posedge clk) begin
            if (!rst_n || mon_clr) begin
                ack_r <= 1'b0; pwr_r <= '0; mreq_d <= 1'b0; held <= '0;
                duty_log <= '0; burst_log <= '0;
                wait_cnt <= 0; meas_cnt <= 0; ms_cnt <= 0; ena_run <= 0;
                bursts <= 0; bad <= 0; unstable <= 0; idle_nz <= 0;
            end else begin
                ack_r <= 1'b0;
                if (ifc.meas_req && !ack_r) begin
                    if (wait_cnt == ack_delay - 1) begin
                        ack_r    <= 1'b1;
                        pwr_r    <= pwr_seq[meas_cnt % 4];
                        meas_cnt <= meas_cnt + 1;
                        wait_cnt <= 0;
                    end else begin
                        wait_cnt <= wait_cnt + 1;
                    end
                end
                mreq_d <= ifc.meas_req;
                if (ifc.meas_req && !mreq_d) begin
                    if (ms_cnt < 8) duty_log[ms_cnt*16 +: 16] <= ifc.duty_out;
                    ms_cnt <= ms_cnt + 1;
                end
                if (ifc.upd_ena) begin
                    if (ena_run == 0) begin
                        held <= upd_bus;
                        if (bursts < 8) burst_log[bursts*64 +: 64] <= upd_bus;
                    end else if (upd_bus !== held) begin
                        unstable <= unstable + 1;
                    end
                    ena_run <= ena_run + 1;
                end else begin
                    if (ena_run != 0) begin
                        bursts <= bursts + 1;
                        if (ena_run != 4) bad <= bad + 1;
                    end
                    ena_run <= 0;
                    if (upd_bus !== 64'd0) idle_nz <= idle_nz + 1;
                end
            end
        end
    end

    task automatic pulse_start(input int d);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr  = 1'b0;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget);
        int n = 0;
        while (done_w[d] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++; if (done_w[d] !== 1'b1) begin errors++; $display("FAIL done_timeout dut%0d: no done within %0d cycles", d, budget); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (busy_w[d] !== 1'b0)  begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_w[d]); end
            checks++; if (done_w[d] !== 1'b0)  begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", d, done_w[d]); end
            checks++; if (mreq_w[d] !== 1'b0)  begin errors++; $display("FAIL reset_meas_req dut%0d: got %b want 0", d, mreq_w[d]); end
            checks++; if (uena_w[d] !== 1'b0)  begin errors++; $display("FAIL reset_upd_ena dut%0d: got %b want 0", d, uena_w[d]); end
            checks++; if (duty_w[d] !== 16'h0) begin errors++; $display("FAIL reset_duty dut%0d: got %h want 0", d, duty_w[d]); end
            checks++; if (iter_w[d] !== 6'd0)  begin errors++; $display("FAIL reset_iter dut%0d: got %0d want 0", d, iter_w[d]); end
            checks++; if (gbx_w[d] !== 16'h0)  begin errors++; $display("FAIL reset_gbest_x dut%0d: got %h want 0", d, gbx_w[d]); end
            checks++; if (gbp_w[d] !== 16'h0)  begin errors++; $display("FAIL reset_gbest_pwr dut%0d: got %h want 0", d, gbp_w[d]); end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++; if (done_w[d] !== 1'b0 || busy_w[d] !== 1'b0) begin errors++; $display("FAIL release_quiet dut%0d: done=%b busy=%b want 0/0", d, done_w[d], busy_w[d]); end
        end
    endtask

    task automatic test_tie_break();
        ack_delay = 3;
        pwr_seq[0] = 16'd10; pwr_seq[1] = 16'd40; pwr_seq[2] = 16'd40; pwr_seq[3] = 16'd20;
        stub_v = 32'h0002_0000;
        stub_x = 32'h0001_0000;
        pulse_start(0);
        checks++; if (busy_w[0] !== 1'b1)  begin errors++; $display("FAIL tie_busy_after_start: got %b want 1", busy_w[0]); end
        checks++; if (mreq_w[0] !== 1'b1)  begin errors++; $display("FAIL tie_meas_req: got %b want 1", mreq_w[0]); end
        checks++; if (duty_w[0] !== SEED0) begin errors++; $display("FAIL tie_first_duty: got %h want %h", duty_w[0], SEED0); end
        checks++; if (gbx_w[0] !== SEED0)  begin errors++; $display("FAIL tie_gbest_x_init: got %h want %h", gbx_w[0], SEED0); end
        wait_done(0, 500);
        checks++; if (busy_w[0] !== 1'b0)     begin errors++; $display("FAIL tie_busy_at_done: got %b want 0", busy_w[0]); end
        checks++; if (gbp_w[0] !== 16'd40)    begin errors++; $display("FAIL tie_gbest_pwr: got %0d want 40", gbp_w[0]); end
        checks++; if (gbx_w[0] !== SEED1)     begin errors++; $display("FAIL tie_gbest_x: got %h want %h", gbx_w[0], SEED1); end
        checks++; if (iter_w[0] !== 6'd1)     begin errors++; $display("FAIL tie_iter: got %0d want 1", iter_w[0]); end
        checks++; if (meas_cnt_w[0] !== 32'd4) begin errors++; $display("FAIL tie_meas_count: got %0d want 4", meas_cnt_w[0]); end
        checks++; if (bursts_w[0] !== 32'd4)  begin errors++; $display("FAIL tie_bursts: got %0d want 4", bursts_w[0]); end
        checks++; if (bad_w[0] !== 32'd0)     begin errors++; $display("FAIL tie_burst_length: got %0d bad bursts want 0", bad_w[0]); end
        checks++; if (unstable_w[0] !== 32'd0) begin errors++; $display("FAIL tie_upd_stable: got %0d changes want 0", unstable_w[0]); end
        checks++; if (idle_nz_w[0] !== 32'd0) begin errors++; $display("FAIL tie_upd_idle_zero: got %0d nonzero cycles want 0", idle_nz_w[0]); end
        @(negedge clk);
        checks++; if (done_w[0] !== 1'b0)     begin errors++; $display("FAIL tie_done_one_cycle: got %b want 0", done_w[0]); end
    endtask

    task automatic test_ignore();
        int n = 0;
        pulse_start(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (uena_w[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (uena_w[0] !== 1'b1) begin errors++; $display("FAIL ign_upd_timeout: upd_ena not seen"); end
        stray_ack[0] = 1'b1;
        @(negedge clk);
        stray_ack[0] = 1'b0;
        wait_done(0, 500);
        checks++; if (gbp_w[0] !== 16'd40)     begin errors++; $display("FAIL ign_gbest_pwr: got %0d want 40", gbp_w[0]); end
        checks++; if (gbx_w[0] !== SEED1)      begin errors++; $display("FAIL ign_gbest_x: got %h want %h", gbx_w[0], SEED1); end
        checks++; if (meas_cnt_w[0] !== 32'd4) begin errors++; $display("FAIL ign_meas_count: got %0d want 4", meas_cnt_w[0]); end
        checks++; if (ms_cnt_w[0] !== 32'd4)   begin errors++; $display("FAIL ign_meas_starts: got %0d want 4", ms_cnt_w[0]); end
        checks++; if (bursts_w[0] !== 32'd4)   begin errors++; $display("FAIL ign_bursts: got %0d want 4", bursts_w[0]); end
        checks++; if (iter_w[0] !== 6'd1)      begin errors++; $display("FAIL ign_iter: got %0d want 1", iter_w[0]); end
        @(negedge clk);
        stray_ack[0] = 1'b1;
        @(negedge clk);
        stray_ack[0] = 1'b0;
        @(negedge clk);
        checks++; if (busy_w[0] !== 1'b0 || gbp_w[0] !== 16'd40) begin errors++; $display("FAIL ign_idle_ack: busy=%b gbest_pwr=%0d want 0/40", busy_w[0], gbp_w[0]); end
    endtask

    task automatic test_full_run();
        pwr_seq[0] = 16'd100; pwr_seq[1] = 16'd300; pwr_seq[2] = 16'd200; pwr_seq[3] = 16'd50;
        stub_v = 32'h0002_0000;
        stub_x = 32'h0001_0000;
        pulse_start(1);
        wait_done(1, 5000);
        checks++; if (iter_w[1] !== 6'd60)       begin errors++; $display("FAIL full_iter: got %0d want 60", iter_w[1]); end
        checks++; if (busy_w[1] !== 1'b0)        begin errors++; $display("FAIL full_busy_at_done: got %b want 0", busy_w[1]); end
        checks++; if (gbp_w[1] !== 16'd300)      begin errors++; $display("FAIL full_gbest_pwr: got %0d want 300", gbp_w[1]); end
        checks++; if (gbx_w[1] !== SEED1)        begin errors++; $display("FAIL full_gbest_x: got %h want %h", gbx_w[1], SEED1); end
        checks++; if (meas_cnt_w[1] !== 32'd240) begin errors++; $display("FAIL full_meas_count: got %0d want 240", meas_cnt_w[1]); end
        checks++; if (bursts_w[1] !== 32'd240)   begin errors++; $display("FAIL full_bursts: got %0d want 240", bursts_w[1]); end
        checks++; if (bad_w[1] !== 32'd0 || unstable_w[1] !== 32'd0 || idle_nz_w[1] !== 32'd0) begin
            errors++; $display("FAIL full_upd_protocol: bad=%0d unstable=%0d idle_nz=%0d want 0/0/0", bad_w[1], unstable_w[1], idle_nz_w[1]);
        end
        checks++; if (duty_log_w[1][4*16 +: 16] !== X_MAX) begin errors++; $display("FAIL full_clamp_xmax_p0: got %h want %h", duty_log_w[1][4*16 +: 16], X_MAX); end
        checks++; if (duty_log_w[1][7*16 +: 16] !== X_MAX) begin errors++; $display("FAIL full_clamp_xmax_p3: got %h want %h", duty_log_w[1][7*16 +: 16], X_MAX); end
        checks++; if (burst_log_w[1][0*64 +: 64] !== 64'h0000_1000_2000_1000) begin errors++; $display("FAIL full_burst0: got %h want 0000100020001000", burst_log_w[1][0*64 +: 64]); end
        checks++; if (burst_log_w[1][1*64 +: 64] !== 64'h0000_2000_2000_2000) begin errors++; $display("FAIL full_burst1: got %h want 0000200020002000", burst_log_w[1][1*64 +: 64]); end
        checks++; if (burst_log_w[1][4*64 +: 64] !== 64'hFFFF_1000_2000_F000) begin errors++; $display("FAIL full_burst4_vsat: got %h want ffff10002000f000", burst_log_w[1][4*64 +: 64]); end
        @(negedge clk);
        checks++; if (done_w[1] !== 1'b0) begin errors++; $display("FAIL full_done_one_cycle: got %b want 0", done_w[1]); end
        repeat (10) @(negedge clk);
        checks++; if (gbp_w[1] !== 16'd300 || gbx_w[1] !== SEED1 || iter_w[1] !== 6'd60) begin
            errors++; $display("FAIL full_hold: gbest_pwr=%0d gbest_x=%h iter=%0d want 300/%h/60", gbp_w[1], gbx_w[1], iter_w[1], SEED1);
        end
    endtask

    task automatic test_clamp_min();
        int n = 0;
        stub_v = 32'h0;
        stub_x = 32'h0;
        pulse_start(1);
        checks++; if (gbp_w[1] !== 16'd0 || iter_w[1] !== 6'd0 || gbx_w[1] !== SEED0) begin
            errors++; $display("FAIL min_restart_clear: gbest_pwr=%0d iter=%0d gbest_x=%h want 0/0/%h", gbp_w[1], iter_w[1], gbx_w[1], SEED0);
        end
        while (ms_cnt_w[1] < 32'd5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (duty_log_w[1][4*16 +: 16] !== X_MIN) begin errors++; $display("FAIL min_clamp_xmin: got %h want %h", duty_log_w[1][4*16 +: 16], X_MIN); end
    endtask

    task automatic test_reset_mid_run();
        checks++; if (mreq_w[1] !== 1'b1) begin errors++; $display("FAIL mid_in_meas_wait: meas_req=%b want 1", mreq_w[1]); end
        rst_n = 1'b0;
        #1;
        checks++; if (mreq_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: meas_req=%b busy=%b want 0/0", mreq_w[1], busy_w[1]); end
        checks++; if (duty_w[1] !== 16'h0 || gbp_w[1] !== 16'h0 || iter_w[1] !== 6'd0) begin
            errors++; $display("FAIL mid_reset_regs: duty=%h gbest_pwr=%h iter=%0d want 0/0/0", duty_w[1], gbp_w[1], iter_w[1]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || mreq_w[1] !== 1'b0) begin
            errors++; $display("FAIL mid_release_quiet: done=%b busy=%b meas_req=%b want 0/0/0", done_w[1], busy_w[1], mreq_w[1]);
        end
        pulse_start(1);
        checks++; if (duty_w[1] !== SEED0 || mreq_w[1] !== 1'b1 || busy_w[1] !== 1'b1) begin
            errors++; $display("FAIL mid_clean_restart: duty=%h meas_req=%b busy=%b want %h/1/1", duty_w[1], mreq_w[1], busy_w[1], SEED0);
        end
    endtask

    initial begin
        start[0] = 1'b0; start[1] = 1'b0;
        stray_ack[0] = 1'b0; stray_ack[1] = 1'b0;
        mon_clr = 1'b0;
        ack_delay = 3;
        for (int i = 0; i < 4; i++) pwr_seq[i] = '0;
        stub_v = '0;
        stub_x = '0;
        test_reset();
        test_tie_break();
        test_ignore();
        test_full_run();
        test_clamp_min();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
